// File: rtl/fifo_pkg.sv
// Shared defaults for the parametrised FIFO: data/address widths, the depth
// helper and the almost-full / almost-empty threshold defaults.
package fifo_pkg;

    localparam int DW_DEF       = 4;
    localparam int AW_DEF       = 3;
    localparam int AFULL_TH_DEF = 6;
    localparam int AEMP_TH_DEF  = 1;

    // Number of entries addressed by an aw-bit pointer.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fifo_rf.sv
// FIFO storage: 2**AW x DW register file, one synchronous write port and two
// asynchronous read ports (FIFO head and display scanner). Not reset.
module fifo_rf
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra0,
    output logic [DW-1:0] rd0,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1
);

    localparam int DEPTH = fifo_depth(AW);

    logic [DW-1:0] mem [DEPTH];

    // Write port: the old word stays visible on the read ports until the edge.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/param_fifo.sv
// Parametrised circular-buffer FIFO with occupancy count, sticky overflow /
// underflow flags, per-slot valid map and a debug read port for the display.
// Optional build macro FIFO_EDGE_EN: enq/deq are rising-edge detected so a
// held button gives a single operation; otherwise they are level-sensitive.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int AFULL_TH = AFULL_TH_DEF,
    parameter int AEMP_TH  = AEMP_TH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enq,
    input  logic [DW-1:0]             din,
    input  logic                      deq,
    output logic [DW-1:0]             dout,
    output logic                      emp,
    output logic                      full,
    output logic                      afull,
    output logic                      aemp,
    output logic [AW:0]               count,
    output logic                      ovf,
    output logic                      udf,
    output logic [AW-1:0]             head,
    output logic [fifo_depth(AW)-1:0] valid,
    input  logic [AW-1:0]             dbg_addr,
    output logic [DW-1:0]             dbg_data
);

    localparam int         DEPTH   = fifo_depth(AW);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMP_C  = (AW+1)'(AEMP_TH);

    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q;
    logic [DW-1:0] dout_q, rd_head;
    logic          ovf_q, udf_q;
    logic          enq_i, deq_i, enq_ok, deq_ok;

`ifdef FIFO_EDGE_EN
    logic enq_d, deq_d;

    // Previous request levels; cleared by reset so a request held through
    // reset release still registers as one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            enq_d <= 1'b0;
            deq_d <= 1'b0;
        end else begin
            enq_d <= enq;
            deq_d <= deq;
        end
    end

    assign enq_i = enq & ~enq_d;
    assign deq_i = deq & ~deq_d;
`else
    assign enq_i = enq;
    assign deq_i = deq;
`endif

    assign emp    = (count_q == '0);
    assign full   = (count_q == DEPTH_C);
    assign afull  = (count_q >= AFULL_C);
    assign aemp   = (count_q <= AEMP_C);

    // A simultaneous dequeue frees the slot, so enqueue is allowed when full.
    assign enq_ok = enq_i & (~full | deq_i);
    assign deq_ok = deq_i & ~emp;

    fifo_rf #(.DW(DW), .AW(AW)) u_rf (
        .clk (clk),
        .we  (enq_ok & ~rst),
        .wa  (tail_q),
        .wd  (din),
        .ra0 (head_q),
        .rd0 (rd_head),
        .ra1 (dbg_addr),
        .rd1 (dbg_data)
    );

    // Pointers, occupancy, output register and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (enq_ok) tail_q <= tail_q + 1'b1;
            if (deq_ok) begin
                head_q <= head_q + 1'b1;
                dout_q <= rd_head;
            end
            count_q <= count_q + (AW+1)'(enq_ok) - (AW+1)'(deq_ok);
            if (enq_i & ~enq_ok) ovf_q <= 1'b1;
            if (deq_i & ~deq_ok) udf_q <= 1'b1;
        end
    end

    // Slot i is occupied when its distance from head is below the count.
    always_comb begin
        logic [AW-1:0] off;
        off   = '0;
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = AW'(i) - head_q;
            valid[i] = ({1'b0, off} < count_q);
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
    assign head  = head_q;

endmodule
